// File: rtl/intr_controller_if.sv
// rtl/intr_controller_if.sv - request, mask, acknowledge and status bundle for intr_controller
interface intr_controller_if #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 3
);
  logic [N_IRQ-1:0] interrupt_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             intr_ack;
  logic             s_return_intr;
  logic             s_stop_opcode;
  logic [VEC_W-1:0] intr_vec;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] in_service;
  logic [N_IRQ-1:0] mask_q;

  modport master (
    output interrupt_in, mask_we, mask_wdata, intr_ack, s_return_intr,
    input  s_stop_opcode, intr_vec, pending, in_service, mask_q
  );

  modport slave (
    input  interrupt_in, mask_we, mask_wdata, intr_ack, s_return_intr,
    output s_stop_opcode, intr_vec, pending, in_service, mask_q
  );
endinterface

// File: rtl/intr_controller.sv
// rtl/intr_controller.sv - fixed-priority edge-triggered interrupt controller; INTR_NESTING_EN enables preemption
module intr_controller #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 3
) (
  input logic               clk,
  input logic               reset,
  intr_controller_if.slave  bus
);

  logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;
  logic [N_IRQ-1:0] mask_q, mask_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] ack_sel;
  logic [N_IRQ-1:0] ret_sel;
  logic [VEC_W-1:0] vec;
  logic             stop;
  logic             ack_fire;

  assign rise = bus.interrupt_in & ~irq_prev_q;

`ifdef INTR_NESTING_EN
  logic [N_IRQ-1:0] below;
  logic             clear_run;

  // A line qualifies only when no in-service line has equal or higher priority
  always_comb begin
    below     = '0;
    clear_run = 1'b1;
    for (int i = 0; i < N_IRQ; i++) begin
      clear_run = clear_run & ~in_service_q[i];
      below[i]  = clear_run;
    end
    eligible = pending_q & mask_q & below;
  end
`else
  // Without nesting, any active service blocks all new presentations
  always_comb begin
    eligible = '0;
    if (in_service_q == '0) begin
      eligible = pending_q & mask_q;
    end
  end
`endif

  // Lowest eligible index wins; vector reads 0 when nothing is eligible
  always_comb begin
    vec = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        vec = VEC_W'(i);
      end
    end
  end

  assign stop     = |eligible;
  assign ack_fire = bus.intr_ack & stop;
  // Isolate lowest set bit: x & -x
  assign ack_sel  = eligible & (~eligible + N_IRQ'(1));
  assign ret_sel  = in_service_q & (~in_service_q + N_IRQ'(1));

  // Next-state: ack clears pending but a same-cycle rise re-sets it; return acts on pre-edge in_service
  always_comb begin
    irq_prev_d   = bus.interrupt_in;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    mask_d       = mask_q;
    if (ack_fire) begin
      pending_d = pending_d & ~ack_sel;
    end
    pending_d = pending_d | rise;
    if (bus.s_return_intr) begin
      in_service_d = in_service_d & ~ret_sel;
    end
    if (ack_fire) begin
      in_service_d = in_service_d | ack_sel;
    end
    if (bus.mask_we) begin
      mask_d = bus.mask_wdata;
    end
  end

  // State registers; irq_prev resets high so lines held through reset raise nothing
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_prev_q   <= '1;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '1;
    end else begin
      irq_prev_q   <= irq_prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
    end
  end

  assign bus.s_stop_opcode = stop;
  assign bus.intr_vec      = vec;
  assign bus.pending       = pending_q;
  assign bus.in_service    = in_service_q;
  assign bus.mask_q        = mask_q;

endmodule

// File: tb/tb_intr_controller.sv
// tb/tb_intr_controller.sv - directed scoreboard bench for intr_controller
module tb_intr_controller;

  typedef struct {
    string      tag;
    logic       stop;
    logic [2:0] vec;
    logic [7:0] pend;
    logic [7:0] isv;
    logic [7:0] mask;
  } exp_t;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  intr_controller_if #(.N_IRQ(8), .VEC_W(3)) bus ();

  intr_controller #(.N_IRQ(8), .VEC_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic stop, input logic [2:0] vec,
                      input logic [7:0] pend, input logic [7:0] isv, input logic [7:0] mask);
    exp_t e;
    e.tag = tag; e.stop = stop; e.vec = vec; e.pend = pend; e.isv = isv; e.mask = mask;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".stop"}, {7'b0, bus.s_stop_opcode}, {7'b0, e.stop});
    chk({e.tag, ".vec"},  {5'b0, bus.intr_vec},      {5'b0, e.vec});
    chk({e.tag, ".pend"}, bus.pending,               e.pend);
    chk({e.tag, ".isv"},  bus.in_service,            e.isv);
    chk({e.tag, ".mask"}, bus.mask_q,                e.mask);
    bus.intr_ack      = 1'b0;
    bus.s_return_intr = 1'b0;
    bus.mask_we       = 1'b0;
  endtask

  initial begin
    n_assert          = 0;
    n_fail            = 0;
    reset             = 1'b0;
    bus.interrupt_in  = 8'hFF;
    bus.mask_we       = 1'b0;
    bus.mask_wdata    = 8'h00;
    bus.intr_ack      = 1'b0;
    bus.s_return_intr = 1'b0;

    step("rst0", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
    step("rst1", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
    reset = 1'b1;
    step("hold_ff0", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
    step("hold_ff1", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
    bus.interrupt_in = 8'h00;
    step("drop", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
    bus.interrupt_in = 8'h20;
    step("rise5", 1'b1, 3'd5, 8'h20, 8'h00, 8'hFF);
    bus.intr_ack = 1'b1;
    step("ack5", 1'b0, 3'd0, 8'h00, 8'h20, 8'hFF);
    bus.s_return_intr = 1'b1;
    step("ret5", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
    bus.interrupt_in = 8'h00;
    step("idle_a", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);

    bus.interrupt_in = 8'h44;
    step("rise62", 1'b1, 3'd2, 8'h44, 8'h00, 8'hFF);
    bus.intr_ack = 1'b1;
    step("ack2", 1'b0, 3'd0, 8'h40, 8'h04, 8'hFF);
    bus.s_return_intr = 1'b1;
    step("ret2", 1'b1, 3'd6, 8'h40, 8'h00, 8'hFF);
    bus.intr_ack = 1'b1;
    step("ack6", 1'b0, 3'd0, 8'h00, 8'h40, 8'hFF);
    bus.s_return_intr = 1'b1;
    step("ret6", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
    bus.interrupt_in = 8'h00;
    step("idle_b", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);

    bus.mask_we = 1'b1; bus.mask_wdata = 8'hFB;
    step("mask_fb", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFB);
    bus.interrupt_in = 8'h04;
    step("masked2", 1'b0, 3'd0, 8'h04, 8'h00, 8'hFB);
    bus.mask_we = 1'b1; bus.mask_wdata = 8'hFF;
    step("unmask2", 1'b1, 3'd2, 8'h04, 8'h00, 8'hFF);
    bus.intr_ack = 1'b1;
    step("ack2m", 1'b0, 3'd0, 8'h00, 8'h04, 8'hFF);
    bus.s_return_intr = 1'b1;
    step("ret2m", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
    bus.interrupt_in = 8'h00;
    step("idle_c", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);

    bus.interrupt_in = 8'h10;
    step("rise4", 1'b1, 3'd4, 8'h10, 8'h00, 8'hFF);
    bus.intr_ack = 1'b1;
    step("ack4", 1'b0, 3'd0, 8'h00, 8'h10, 8'hFF);
    bus.interrupt_in = 8'h12;
`ifdef INTR_NESTING_EN
    step("rise1n", 1'b1, 3'd1, 8'h02, 8'h10, 8'hFF);
    bus.intr_ack = 1'b1;
    step("ack1n", 1'b0, 3'd0, 8'h00, 8'h12, 8'hFF);
    bus.s_return_intr = 1'b1;
    step("ret1n", 1'b0, 3'd0, 8'h00, 8'h10, 8'hFF);
    bus.s_return_intr = 1'b1;
    step("ret4n", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
`else
    step("rise1b", 1'b0, 3'd0, 8'h02, 8'h10, 8'hFF);
    bus.intr_ack = 1'b1;
    step("ack_ign", 1'b0, 3'd0, 8'h02, 8'h10, 8'hFF);
    bus.s_return_intr = 1'b1;
    step("ret4b", 1'b1, 3'd1, 8'h02, 8'h00, 8'hFF);
    bus.intr_ack = 1'b1;
    step("ack1b", 1'b0, 3'd0, 8'h00, 8'h02, 8'hFF);
    bus.s_return_intr = 1'b1;
    step("ret1b", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
`endif
    bus.interrupt_in = 8'h00;
    step("idle_d", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);

    bus.interrupt_in = 8'h08;
    step("rise3", 1'b1, 3'd3, 8'h08, 8'h00, 8'hFF);
    bus.interrupt_in = 8'h00;
    step("hold3", 1'b1, 3'd3, 8'h08, 8'h00, 8'hFF);
    bus.interrupt_in = 8'h08; bus.intr_ack = 1'b1;
    step("ack3_rise", 1'b0, 3'd0, 8'h08, 8'h08, 8'hFF);
    bus.interrupt_in = 8'h09;
`ifdef INTR_NESTING_EN
    step("rise0n", 1'b1, 3'd0, 8'h09, 8'h08, 8'hFF);
    bus.intr_ack = 1'b1; bus.s_return_intr = 1'b1;
    step("ret_ack_n", 1'b0, 3'd0, 8'h08, 8'h01, 8'hFF);
`else
    step("rise0b", 1'b0, 3'd0, 8'h09, 8'h08, 8'hFF);
    bus.intr_ack = 1'b1; bus.s_return_intr = 1'b1;
    step("ret_ack_b", 1'b1, 3'd0, 8'h09, 8'h00, 8'hFF);
    bus.intr_ack = 1'b1;
    step("ack0b", 1'b0, 3'd0, 8'h08, 8'h01, 8'hFF);
`endif

    reset = 1'b0;
    step("mid_reset", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);
    reset = 1'b1;
    step("post_reset", 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_controller.md
# intr_controller

Parametrised interrupt controller for the basic CPU, successor to the fixed 8-line manager. Handles N_IRQ edge-triggered sources with a software-writable mask, fixed priority, per-line pending and in-service state, and an explicit acknowledge handshake. It stalls opcode fetch via `s_stop_opcode`, presents a binary vector to the control unit and retires service on `s_return_intr`. Nested preemption is available as a compile-time option.

## Interface
- `N_IRQ`, 8: number of interrupt lines, 2..32; line 0 has the highest priority.
- `VEC_W`, 3: vector width; requires 2^VEC_W >= N_IRQ.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `interrupt_in` in N_IRQ: raw request lines, level in, rising-edge detected.
- `mask_we` in 1: mask write strobe.
- `mask_wdata` in N_IRQ: new mask value; 1 = line enabled.
- `intr_ack` in 1: CPU accepts the presented interrupt.
- `s_return_intr` in 1: CPU executed return-from-interrupt.
- `s_stop_opcode` out 1: an eligible interrupt is waiting; CPU must stop fetch and ack.
- `intr_vec` out VEC_W: index of the presented interrupt; 0 when `s_stop_opcode`=0.
- `pending` out N_IRQ: pending register.
- `in_service` out N_IRQ: in-service register.
- `mask_q` out N_IRQ: current mask.

## Operation
- Registers: `irq_prev`, `pending`, `in_service`, `mask_q`. All outputs derive from registers only; there is no combinational input-to-output path.
- Edge detect: `rise = interrupt_in & ~irq_prev`; `irq_prev <= interrupt_in` every cycle.
- Pending: `pending[i]` is set by `rise[i]` and is sticky. It is cleared only by an ack of line i. If an ack of line i and `rise[i]` occur in the same cycle, the set wins and the line stays pending.
- Mask: on `mask_we`, `mask_q <= mask_wdata`. The mask gates eligibility only; it never clears `pending`.
- Eligibility:
  - Without nesting: `eligible = pending & mask_q` when `in_service`==0, otherwise 0.
  - With nesting: line i is eligible if it is pending, unmasked, and i < the lowest set index of `in_service`. All lines qualify when `in_service`==0.
- Output selection: `s_stop_opcode` = |eligible. `intr_vec` = lowest set index of `eligible`.
- Ack: when `intr_ack` && `s_stop_opcode`, clear `pending[intr_vec]` and set `in_service[intr_vec]`. An `intr_ack` while `s_stop_opcode`=0 is ignored.
- Return: `s_return_intr` clears the lowest set bit of the pre-edge `in_service`. A return with `in_service`==0 is ignored.
- Return and ack in the same cycle: both apply. The return acts on the pre-edge `in_service`, so the newly acked bit survives.
- Per-line states are idle, pending, in-service, and pending+in-service (the line re-triggered while being serviced). With nesting off, a re-triggered line is presented again after its return.

## Timing
- Reset (`reset`=0 at an edge): `pending`=0, `in_service`=0, `mask_q`=all ones, `irq_prev`=all ones. As a result:
  - `s_stop_opcode`=0 and `intr_vec`=0.
  - Lines held high through reset generate no request.
- A reset asserted mid-service drops all pending and in-service state at that edge.
- Request latency: a rising edge sampled at edge E produces `pending` and `s_stop_opcode` in the cycle after E (1 cycle).
- Ack latency: ack sampled at edge F updates `in_service`, `intr_vec` and `s_stop_opcode` after F. The next eligible line can be presented the cycle after F.
- Return latency: a return at edge R can re-present a blocked line the cycle after R.
- Mask latency: a mask write at edge M affects eligibility from the cycle after M.
- Lines that stay high produce exactly one request per rising edge. Pulses must be at least one cycle wide to be seen.

## Configuration
- `INTR_NESTING_EN` defined: higher-priority lines preempt an active service, and `in_service` may hold multiple bits.
- `INTR_NESTING_EN` undefined: at most one `in_service` bit is set, and nothing is presented until the return.

## Test plan
- Reset release with `interrupt_in`=8'hFF held high: `s_stop_opcode` stays 0. Drop the lines and raise bit 5: one cycle later `s_stop_opcode`=1, `intr_vec`=5.
- Rise bits 6 and 2 together: vec=2. After ack, `in_service`=8'h04. After return, vec=6 is presented.
- Write `mask_wdata`=8'hFB, then rise bit 2: `pending`=8'h04 and `s_stop_opcode`=0. Write 8'hFF: the next cycle `s_stop_opcode`=1, vec=2.
- Nesting on: ack line 4, then rise line 1: vec=1, and after ack `in_service`=8'h12. First return gives 8'h10, second return gives 8'h00.
- Nesting off, same stimulus: line 1 is held until the return of line 4, then presented.
- Ack line 3 while bit 3 rises again: `pending[3]` stays 1 and `in_service[3]`=1. A return and an ack in the same cycle: the old bit clears and the new bit is set.
